// File: rtl/rect_fill_pkg.sv
// Shared types and default screen geometry for the rectangle fill engine.
// Contents: state_t (fill FSM states), mode_t (colour modes), default
// framebuffer size and coordinate/colour widths.
package rect_fill_pkg;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;
  localparam int unsigned DEF_XW       = 8;
  localparam int unsigned DEF_YW       = 7;
  localparam int unsigned DEF_CW       = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M_SOLID,
    M_COL,
    M_ROW,
    M_CHECK
  } mode_t;

endpackage

// File: rtl/rect_colour_gen.sv
// Combinational pixel colour generator for the fill engines.
// Ports:
//   mode    - colour mode (solid, column stripe, row stripe, checker)
//   x, y    - low CW bits of the absolute pixel coordinates
//   colour  - base colour of the request
//   pixel_c - resulting pixel colour (combinational)
module rect_colour_gen
  import rect_fill_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  mode_t         mode,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] colour,
  output logic [CW-1:0] pixel_c
);

  // Stripes use the coordinate itself as colour; checker flips on odd parity.
  always_comb begin
    pixel_c = colour;
    case (mode)
      M_SOLID: pixel_c = colour;
      M_COL:   pixel_c = x;
      M_ROW:   pixel_c = y;
      M_CHECK: pixel_c = (x[0] ^ y[0]) ? ~colour : colour;
      default: pixel_c = colour;
    endcase
  end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: paints an axis-aligned w x h rectangle at (x0, y0)
// into the VGA adapter, one pixel per clock, column-major (y inner, x outer).
// Optional feature macro: RECT_FILL_CLIP_EN -- suppresses the plot strobe for
// pixels outside SCREEN_W x SCREEN_H (the cycle is still spent).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - level request, held until done
//   x0, y0, w, h    - rectangle origin and size (zero size is legal)
//   mode, colour    - colour mode and base colour
//   done            - completion flag, held until start falls
//   vga_x, vga_y, vga_colour, vga_plot - registered plot interface
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned XW       = DEF_XW,
  parameter int unsigned YW       = DEF_YW,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW:0]   w,
  input  logic [YW:0]   h,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] colour,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [YW-1:0] y0_q, y0_d;
  logic [XW:0]   w_q, w_d, dx_q, dx_d;
  logic [YW:0]   h_q, h_d, dy_q, dy_d;
  mode_t         mode_q, mode_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          done_d;
  logic          emit;

  logic          col_end, last_px;
  logic [XW:0]   nxt_dx;
  logic [YW:0]   nxt_dy;

  logic [XW-1:0] base_x, off_x, abs_x;
  logic [YW-1:0] base_y, off_y, abs_y;
  mode_t         pix_mode;
  logic [CW-1:0] pix_base;
  logic [CW-1:0] pix_colour;
  logic          in_bounds;
  logic          pixel_load;

  // Offset advance: dy walks down a column, dx steps at the column end.
  always_comb begin
    col_end = (dy_q == h_q - (YW+1)'(1));
    last_px = col_end && (dx_q == w_q - (XW+1)'(1));
    nxt_dx  = col_end ? dx_q + (XW+1)'(1) : dx_q;
    nxt_dy  = col_end ? '0 : dy_q + (YW+1)'(1);
  end

  // The pixel loaded this edge: from live inputs when starting, else the next offset.
  always_comb begin
    if (state_q == IDLE) begin
      base_x   = x0;
      base_y   = y0;
      off_x    = '0;
      off_y    = '0;
      pix_mode = mode_t'(mode);
      pix_base = colour;
    end else begin
      base_x   = x0_q;
      base_y   = y0_q;
      off_x    = XW'(nxt_dx);
      off_y    = YW'(nxt_dy);
      pix_mode = mode_q;
      pix_base = colour_q;
    end
  end

  assign abs_x = base_x + off_x;
  assign abs_y = base_y + off_y;

`ifdef RECT_FILL_CLIP_EN
  logic [XW+1:0] ux;
  logic [YW+1:0] uy;

  // Unwrapped coordinates for the screen bounds test.
  always_comb begin
    ux = (XW+2)'(base_x);
    uy = (YW+2)'(base_y);
    if (state_q != IDLE) begin
      ux = ux + (XW+2)'(nxt_dx);
      uy = uy + (YW+2)'(nxt_dy);
    end
  end

  assign in_bounds = (ux < (XW+2)'(SCREEN_W)) && (uy < (YW+2)'(SCREEN_H));
`else
  // No bounds test; only a degenerate zero-sized screen suppresses plotting.
  assign in_bounds = (SCREEN_W != 0) && (SCREEN_H != 0);
`endif

  rect_colour_gen #(
    .CW(CW)
  ) u_colour (
    .mode    (pix_mode),
    .x       (CW'(abs_x)),
    .y       (CW'(abs_y)),
    .colour  (pix_base),
    .pixel_c (pix_colour)
  );

  // Next-state and request bookkeeping.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    done_d   = done;
    emit     = 1'b0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          w_d      = w;
          h_d      = h;
          mode_d   = mode_t'(mode);
          colour_d = colour;
          dx_d     = '0;
          dy_d     = '0;
          if (w == '0 || h == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
            emit    = 1'b1;
          end
        end
      end
      FILL: begin
        if (last_px) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          dx_d = nxt_dx;
          dy_d = nxt_dy;
          emit = 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pixel_load = emit && in_bounds;

  // Plot outputs only load on a visible pixel so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      mode_q     <= M_SOLID;
      colour_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      done     <= done_d;
      vga_plot <= pixel_load;
      if (pixel_load) begin
        vga_x      <= abs_x;
        vga_y      <= abs_y;
        vga_colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: table of hand-derived requests, a
// full-screen fill, a reset abort, and randomized requests, all compared
// cycle by cycle against a per-request pixel list built from the fill rules.
module tb_rect_fill;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW:0]   w;
  logic [YW:0]   h;
  logic [1:0]    mode;
  logic [CW-1:0] colour;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  int checks = 0;
  int errors = 0;
  int hx = 0, hy = 0, hc = 0;

  rect_fill dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .mode       (mode),
    .colour     (colour),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, w, h, m, c;
    int plots;
    int lx, ly, lc;
  } vec_t;

  function automatic logic [31:0] tup(input bit p, input bit d, input int x, input int y, input int c);
    return {12'b0, p, d, x[XW-1:0], y[YW-1:0], c[CW-1:0]};
  endfunction

  function automatic logic [31:0] act();
    return {12'b0, vga_plot, done, vga_x, vga_y, vga_colour};
  endfunction

  function automatic int ref_colour(input int m, input int c, input int x, input int y);
    case (m)
      0:       return c;
      1:       return x % (1 << CW);
      2:       return y % (1 << CW);
      default: return (((x % 2) + (y % 2)) % 2 == 0) ? c : ((1 << CW) - 1 - c);
    endcase
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: actual %h required %h", nm, idx, a, e);
    end
  endtask

  // One full request: every cycle compared against the rule-derived pixel list.
  task automatic run_req(input int rx0, input int ry0, input int rw, input int rh,
                         input int rm, input int rc, input int id, output int nplots);
    bit pp[$];
    int px[$], py[$], pc[$];
    for (int dx = 0; dx < rw; dx++) begin
      for (int dy = 0; dy < rh; dy++) begin
        int ux = rx0 + dx;
        int uy = ry0 + dy;
        bit vis = 1'b1;
`ifdef RECT_FILL_CLIP_EN
        vis = (ux < SW) && (uy < SH);
`endif
        pp.push_back(vis);
        px.push_back(ux % (1 << XW));
        py.push_back(uy % (1 << YW));
        pc.push_back(ref_colour(rm, rc, ux % (1 << XW), uy % (1 << YW)));
      end
    end
    nplots = 0;
    x0 = XW'(rx0); y0 = YW'(ry0); w = (XW+1)'(rw); h = (YW+1)'(rh);
    mode = 2'(rm); colour = CW'(rc); start = 1'b1;
    @(posedge clk); #1;
    x0 = XW'($urandom); y0 = YW'($urandom); w = (XW+1)'($urandom);
    h = (YW+1)'($urandom); mode = 2'($urandom); colour = CW'($urandom);
    if (pp.size() == 0) begin
      if (done !== 1'b1) begin
        check("zero_noplot", id, {31'b0, vga_plot}, 32'd0);
        @(posedge clk); #1;
      end
    end else begin
      for (int k = 0; k < pp.size(); k++) begin
        if (pp[k]) begin
          hx = px[k]; hy = py[k]; hc = pc[k];
          nplots++;
        end
        check("pixel", id * 100000 + k, act(), tup(pp[k], 1'b0, hx, hy, hc));
        @(posedge clk); #1;
      end
    end
    check("done_rise", id, act(), tup(1'b0, 1'b1, hx, hy, hc));
    @(posedge clk); #1;
    check("done_hold", id, act(), tup(1'b0, 1'b1, hx, hy, hc));
    start = 1'b0;
    @(posedge clk); #1;
    check("done_clear", id, act(), tup(1'b0, 1'b0, hx, hy, hc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int np;

    vecs[0] = '{x0:10,  y0:20,  w:3,   h:2,  m:0, c:5, plots:6, lx:12, ly:21, lc:5};
    vecs[1] = '{x0:0,   y0:0,   w:2,   h:2,  m:3, c:3, plots:4, lx:1,  ly:1,  lc:3};
    vecs[2] = '{x0:0,   y0:6,   w:2,   h:4,  m:2, c:0, plots:8, lx:1,  ly:9,  lc:1};
    vecs[3] = '{x0:4,   y0:4,   w:0,   h:50, m:0, c:2, plots:0, lx:1,  ly:9,  lc:1};
    vecs[4] = '{x0:4,   y0:4,   w:5,   h:0,  m:0, c:2, plots:0, lx:1,  ly:9,  lc:1};
    vecs[5] = '{x0:5,   y0:7,   w:2,   h:3,  m:1, c:0, plots:6, lx:6,  ly:9,  lc:6};
`ifdef RECT_FILL_CLIP_EN
    vecs[6] = '{x0:158, y0:118, w:4,   h:4,  m:0, c:2, plots:4,   lx:159, ly:119, lc:2};
    vecs[7] = '{x0:255, y0:127, w:1,   h:1,  m:3, c:6, plots:0,   lx:159, ly:119, lc:2};
    vecs[8] = '{x0:0,   y0:0,   w:256, h:1,  m:1, c:0, plots:160, lx:159, ly:0,   lc:7};
`else
    vecs[6] = '{x0:158, y0:118, w:4,   h:4,  m:0, c:2, plots:16,  lx:161, ly:121, lc:2};
    vecs[7] = '{x0:255, y0:127, w:1,   h:1,  m:3, c:6, plots:1,   lx:255, ly:127, lc:6};
    vecs[8] = '{x0:0,   y0:0,   w:256, h:1,  m:1, c:0, plots:256, lx:255, ly:0,   lc:7};
`endif

    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; mode = '0; colour = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset", 0, act(), tup(1'b0, 1'b0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_idle", 0, act(), tup(1'b0, 1'b0, 0, 0, 0));

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].m, vecs[i].c, i, np);
      check("plot_count", i, 32'(np), 32'(vecs[i].plots));
      check("last_pixel", i, act(), tup(1'b0, 1'b0, vecs[i].lx, vecs[i].ly, vecs[i].lc));
    end

    run_req(0, 0, 160, 120, 1, 0, 100, np);
    check("full_count", 100, 32'(np), 32'd19200);

    // Reset at pixel 37 of a full-screen fill, then restart.
    x0 = 8'd7; y0 = 7'd3; w = 9'd160; h = 8'd120; mode = 2'd1; colour = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 37; k++) begin
      hx = 7; hy = 3 + k; hc = 7;
      check("abort_pre", k, act(), tup(1'b1, 1'b0, hx, hy, hc));
      if (k < 37) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    hx = 0; hy = 0; hc = 0;
    check("abort_rst", 0, act(), tup(1'b0, 1'b0, 0, 0, 0));
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_rst", 1, act(), tup(1'b0, 1'b0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 0, act(), tup(1'b0, 1'b0, 0, 0, 0));
    run_req(7, 3, 2, 3, 1, 0, 200, np);
    check("restart_count", 200, 32'(np), 32'd6);

    for (int r = 0; r < 25; r++) begin
      run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 300 + r, np);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
